// File: rtl/display_shift_sequencer_if.sv
// Serial display link request/status bundle: parallel frame plus start/busy/done on the request side,
// and the three registered pin drives (data, shift clock, latch) on the output side.
interface display_shift_sequencer_if #(
    parameter int FRAME_W = 48
);
    logic               i_en;
    logic               i_start;
    logic [FRAME_W-1:0] i_data;
    logic               o_busy;
    logic               o_done;
    logic               o_serial_data;
    logic               o_serial_clk;
    logic               o_serial_latch;

    modport master (
        output i_en, i_start, i_data,
        input  o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch
    );

    modport slave (
        input  i_en, i_start, i_data,
        output o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch
    );
endinterface

// File: rtl/display_shift_sequencer.sv
// Shifts a captured frame MSB-first onto the display shift registers and latches it; done lands
// (2*FRAME_W+1)*CLK_DIV cycles after busy rises. Requests while busy coalesce into one pending frame.
module display_shift_sequencer #(
    parameter int SYS_CLK_HZ   = 5_000_000,
    parameter int SHIFT_CLK_HZ = 1_000_000,
    parameter int NUM_BYTES    = 6
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    display_shift_sequencer_if.slave  bus
);
    localparam int FRAME_W = 8 * NUM_BYTES;
    localparam int DIV_RAW = SYS_CLK_HZ / (2 * SHIFT_CLK_HZ);
    localparam int CLK_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [PH_W-1:0]    phase;
    logic               pending;
    logic               busy_q;
    logic               done_q;
    logic               sdata_q;
    logic               sclk_q;
    logic               latch_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            phase   <= '0;
            pending <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sdata_q <= 1'b0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
        end else if (bus.i_en) begin
            done_q <= 1'b0;
            if (bus.i_start && state != IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.i_start || pending) begin
                        shreg   <= bus.i_data;
                        bit_cnt <= CNT_FRAME;
                        pending <= 1'b0;
                        phase   <= '0;
                        busy_q  <= 1'b1;
                        sdata_q <= bus.i_data[FRAME_W-1];
                        sclk_q  <= 1'b0;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase == PH_LAST) begin
                        phase  <= '0;
                        sclk_q <= 1'b1;
                        state  <= SHIFT_HI;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (phase == PH_LAST) begin
                        phase   <= '0;
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        sclk_q  <= 1'b0;
                        // Next data bit is presented together with the falling shift clock
                        if (bit_cnt == CNT_W'(1)) begin
                            sdata_q <= 1'b0;
                            latch_q <= 1'b1;
                            state   <= LATCH;
                        end else begin
                            sdata_q <= shreg[FRAME_W-2];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                LATCH: begin
                    if (phase == PH_LAST) begin
                        phase   <= '0;
                        latch_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // done_q holds while disabled; masking keeps the pulse deferred until enable returns
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q & bus.i_en;
    assign bus.o_serial_data  = sdata_q;
    assign bus.o_serial_clk   = sclk_q;
    assign bus.o_serial_latch = latch_q;
endmodule

// File: tb/tb_display_shift_sequencer.sv
// Bench for display_shift_sequencer: a small 8-bit instance for the scenario tests and a default
// 48-bit instance; frames are checked against a scoreboard queue filled when stimulus is driven.
module tb_display_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic        sel_big = 1'b0;
    logic [47:0] data = '0;

    always #5 clk = ~clk;

    display_shift_sequencer_if #(.FRAME_W(8))  s_if ();
    display_shift_sequencer_if #(.FRAME_W(48)) b_if ();

    assign s_if.i_en    = en;
    assign s_if.i_start = start & ~sel_big;
    assign s_if.i_data  = data[7:0];
    assign b_if.i_en    = en;
    assign b_if.i_start = start & sel_big;
    assign b_if.i_data  = data;

    display_shift_sequencer #(
        .SYS_CLK_HZ  (4),
        .SHIFT_CLK_HZ(1),
        .NUM_BYTES   (1)
    ) u_small (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (s_if)
    );

    display_shift_sequencer u_big (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (b_if)
    );

    logic busy, done, sdata, sclk, latch;
    assign busy  = sel_big ? b_if.o_busy         : s_if.o_busy;
    assign done  = sel_big ? b_if.o_done         : s_if.o_done;
    assign sdata = sel_big ? b_if.o_serial_data  : s_if.o_serial_data;
    assign sclk  = sel_big ? b_if.o_serial_clk   : s_if.o_serial_clk;
    assign latch = sel_big ? b_if.o_serial_latch : s_if.o_serial_latch;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: frames captured at each shift-clock rising edge, compared when the latch rises
    logic [47:0] exp_q[$];
    logic [47:0] rx = '0;
    logic [47:0] exp_frame;
    int          rx_bits = 0;
    logic        m_sclk = 1'b0;
    logic        m_latch = 1'b0;

    always @(negedge clk) begin
        if (busy === 1'b0) begin
            rx      = '0;
            rx_bits = 0;
        end
        if (sclk === 1'b1 && m_sclk === 1'b0) begin
            rx = {rx[46:0], sdata};
            rx_bits++;
            check("clk_latch_overlap", 64'(latch), 64'd0);
        end
        if (latch === 1'b1 && m_latch === 1'b0) begin
            check("frame_bits", 64'(rx_bits), sel_big ? 64'd48 : 64'd8);
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_frame = exp_q.pop_front();
                check("frame", 64'(rx), 64'(exp_frame));
            end
        end
        m_sclk  = sclk;
        m_latch = latch;
    end

    int busy_first, busy_last, busy_rise_last, done_first, done_cnt;
    int rise_first, rise_cnt, latch_first, latch_last, pw_bad, hold_bad;
    logic [4:0] outs_after_rst;

    // Runs cycles 1..ncyc after the caller has driven cycle 0; inputs for cycle c are set after sampling it
    task automatic observe(input int ncyc, input int s2, input int s3, input int en_from,
                           input int en_to, input int dchg, input logic [47:0] dval, input int rst_at);
        logic [4:0] o, o_prev;
        logic p_busy, p_sclk, seen_fall, prev_en_lo;
        int run;
        busy_first = -1; busy_last = -1; busy_rise_last = -1; done_first = -1; done_cnt = 0;
        rise_first = -1; rise_cnt = 0; latch_first = -1; latch_last = -1; pw_bad = 0; hold_bad = 0;
        outs_after_rst = 5'h1f;
        p_busy = busy; p_sclk = sclk; o_prev = {busy, done, sdata, sclk, latch};
        seen_fall = 1'b0; prev_en_lo = 1'b0; run = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            o = {busy, done, sdata, sclk, latch};
            if (busy && !p_busy) begin
                if (busy_first < 0) busy_first = c;
                busy_rise_last = c;
            end
            if (busy) busy_last = c;
            if (done) begin
                if (done_first < 0) done_first = c;
                done_cnt++;
            end
            if (sclk != p_sclk) begin
                if (sclk) begin
                    rise_cnt++;
                    if (rise_first < 0) rise_first = c;
                    if (seen_fall && run != 2) pw_bad++;
                end else begin
                    seen_fall = 1'b1;
                    if (run != 2) pw_bad++;
                end
                run = 1;
            end else begin
                run++;
            end
            if (!busy) seen_fall = 1'b0;
            if (latch) begin
                if (latch_first < 0) latch_first = c;
                latch_last = c;
            end
            if (prev_en_lo && o !== o_prev) hold_bad++;
            if (c == rst_at + 1) outs_after_rst = o;
            o_prev = o; p_busy = busy; p_sclk = sclk;
            start      = (c == s2) || (c == s3);
            en         = !(c >= en_from && c <= en_to);
            prev_en_lo = !en;
            rst        = (c == rst_at);
            if (c == dchg) data = dval;
        end
        start = 1'b0; en = 1'b1; rst = 1'b0;
    endtask

    task automatic kick(input logic [47:0] d);
        @(negedge clk);
        data  = d;
        start = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_small_outs", 64'({s_if.o_busy, s_if.o_done, s_if.o_serial_data,
                                     s_if.o_serial_clk, s_if.o_serial_latch}), 64'd0);
        check("rst_big_outs", 64'({b_if.o_busy, b_if.o_done, b_if.o_serial_data,
                                   b_if.o_serial_clk, b_if.o_serial_latch}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame
        exp_q.push_back(48'hA5);
        kick(48'hA5);
        observe(40, -1, -1, -1, -1, -1, '0, -1);
        check("basic_busy_first", 64'(busy_first), 64'd1);
        check("basic_busy_last", 64'(busy_last), 64'd34);
        check("basic_rise_first", 64'(rise_first), 64'd3);
        check("basic_rise_cnt", 64'(rise_cnt), 64'd8);
        check("basic_latch_first", 64'(latch_first), 64'd33);
        check("basic_latch_last", 64'(latch_last), 64'd34);
        check("basic_done", 64'(done_first), 64'd35);
        check("basic_done_cnt", 64'(done_cnt), 64'd1);
        check("basic_pulse_width", 64'(pw_bad), 64'd0);

        // Pending request: coalesced, captures data present on the done cycle
        exp_q.push_back(48'hFF);
        exp_q.push_back(48'h3C);
        kick(48'hFF);
        observe(80, 5, 9, -1, -1, 20, 48'h3C, -1);
        check("pend_done_first", 64'(done_first), 64'd35);
        check("pend_busy_rise", 64'(busy_rise_last), 64'd36);
        check("pend_done_cnt", 64'(done_cnt), 64'd2);

        // Enable pause, with a start pulse while disabled
        exp_q.push_back(48'hC3);
        kick(48'hC3);
        observe(70, 15, -1, 10, 19, -1, '0, -1);
        check("pause_hold", 64'(hold_bad), 64'd0);
        check("pause_latch_first", 64'(latch_first), 64'd43);
        check("pause_done", 64'(done_first), 64'd45);
        check("pause_done_cnt", 64'(done_cnt), 64'd1);

        // Reset mid-transfer, then a fresh frame
        kick(48'h96);
        observe(50, -1, -1, -1, -1, -1, '0, 12);
        check("rst_outs_zero", 64'(outs_after_rst), 64'd0);
        check("rst_no_latch", 64'(latch_first), 64'(-1));
        check("rst_no_done", 64'(done_cnt), 64'd0);
        exp_q.push_back(48'h5A);
        kick(48'h5A);
        observe(40, -1, -1, -1, -1, -1, '0, -1);
        check("rst_fresh_done", 64'(done_first), 64'd35);
        check("rst_fresh_rise_cnt", 64'(rise_cnt), 64'd8);

        // Start exactly on the done cycle
        exp_q.push_back(48'h81);
        exp_q.push_back(48'h7E);
        kick(48'h81);
        observe(110, 35, -1, -1, -1, 35, 48'h7E, -1);
        check("ondone_busy_rise", 64'(busy_rise_last), 64'd36);
        check("ondone_done_cnt", 64'(done_cnt), 64'd2);

        // Default configuration
        @(negedge clk);
        sel_big = 1'b1;
        exp_q.push_back(48'h0123456789AB);
        kick(48'h0123456789AB);
        observe(200, -1, -1, -1, -1, -1, '0, -1);
        check("dflt_busy_first", 64'(busy_first), 64'd1);
        check("dflt_rise_cnt", 64'(rise_cnt), 64'd48);
        check("dflt_pulse_width", 64'(pw_bad), 64'd0);
        check("dflt_latch_first", 64'(latch_first), 64'd193);
        check("dflt_latch_last", 64'(latch_last), 64'd194);
        check("dflt_done", 64'(done_first), 64'd195);

        repeat (2) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/display_shift_sequencer.md
# display_shift_sequencer

Sequences the serial display link: captures a parallel frame of segment bytes and shifts it out MSB-first on `o_serial_data`/`o_serial_clk`, then pulses `o_serial_latch` to transfer the frame to the external shift registers. The block sits between the clock's digit/segment encoder and the `uo_out[2:0]` pins. It owns the shift-clock divider and accepts transfer requests through a start/busy/done handshake with a one-deep pending request.

## Interface

- `SYS_CLK_HZ`, default 5_000_000: system clock frequency.
- `SHIFT_CLK_HZ`, default 1_000_000: target serial clock frequency.
- `NUM_BYTES`, default 6: segment bytes per frame. Frame width is `FRAME_W = 8*NUM_BYTES`.
- Derived `CLK_DIV = max(1, SYS_CLK_HZ / (2*SHIFT_CLK_HZ))`, using integer floor. It equals 2 for the defaults.

Ports:

- `i_clk` input 1: system clock; all logic on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_en` input 1: global enable. When low, the block freezes.
- `i_start` input 1: transfer request, sampled every cycle.
- `i_data` input `FRAME_W`: frame to send. Bit `FRAME_W-1` is sent first.
- `o_busy` output 1: a transfer is in progress.
- `o_done` output 1: one-cycle pulse at the end of a transfer.
- `o_serial_data` output 1: serial data, stable while `o_serial_clk` is high.
- `o_serial_clk` output 1: shift clock; the external register samples on its rising edge.
- `o_serial_latch` output 1: storage-register latch pulse.

## Operation

- **States:** IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- **Internal registers:**
  - `shreg[FRAME_W]`
  - bit counter, width `clog2(FRAME_W+1)`
  - phase counter, counts 0..`CLK_DIV-1`
  - `pending` flag
- **IDLE:**
  - Start condition: `i_start` high, or `pending` set.
  - On start, load `shreg <= i_data`, set bit counter to `FRAME_W`, clear `pending`, clear the phase counter, and go to SHIFT_LO.
- **SHIFT_LO:**
  - Outputs: `o_serial_clk=0`, `o_serial_data=shreg[MSB]`.
  - After `CLK_DIV` cycles, go to SHIFT_HI.
- **SHIFT_HI:**
  - Outputs: `o_serial_clk=1`, data unchanged.
  - After `CLK_DIV` cycles, shift `shreg` left by 1 (zero fill) and decrement the bit counter.
  - If the counter reaches 0, go to LATCH; otherwise go to SHIFT_LO.
- **LATCH:**
  - Outputs: `o_serial_latch=1`, `o_serial_clk=0`, `o_serial_data=0`.
  - Held for `CLK_DIV` cycles, then go to IDLE with `o_done=1` for that one cycle.
- **Output values per state:**
  - `o_busy` is 1 in SHIFT_LO, SHIFT_HI and LATCH, and 0 in IDLE.
  - `o_serial_data` is 0 in IDLE.
  - All serial outputs are registered; no combinational path from inputs.
- **`i_start` while busy:** sets `pending`; multiple requests coalesce into one. The pending transfer launches from IDLE in the cycle `o_done` is high and captures `i_data` at that edge, not at request time.
- **`i_start` coinciding with the done cycle:** treated as a normal IDLE start; `pending` is not also set.
- **`i_en=0`:** all state, counters, `shreg` and outputs hold; `i_start` is ignored and does not set `pending`; `o_done` is not asserted while disabled (a pulse due is deferred until enable returns).
- **`i_data` changes mid-transfer:** no effect.

## Timing

- **Reset:**
  - All outputs are 0 and the state is IDLE.
  - `pending=0`, `shreg=0`, counters are 0.
  - Reset mid-transfer aborts immediately: no latch pulse and no `o_done`.
- **Start at edge t0** (`i_start` high in cycle 0, `i_en=1`):
  - `o_busy=1` from cycle 1.
  - Bit k (k=0 is the MSB) has its data valid from cycle `1+2*CLK_DIV*k`.
  - `o_serial_clk` is high in cycles `1+2*CLK_DIV*k+CLK_DIV` through `1+2*CLK_DIV*(k+1)-1`.
  - The latch is high in cycles `1+2*CLK_DIV*FRAME_W` through `+CLK_DIV-1`.
  - `o_done=1` and `o_busy=0` in cycle `1+(2*FRAME_W+1)*CLK_DIV`.
- **Defaults:** with `CLK_DIV=2` and `FRAME_W=48`, `o_done` is in cycle 195.
- **Back-to-back with `pending`:** the next `o_busy` rises in the cycle after `o_done`. The minimum IDLE gap is 1 cycle.
- **Output pulses:** `o_serial_clk` and `o_serial_latch` never overlap, and both are glitch-free.

## Test plan

- **Basic frame:** `NUM_BYTES=1`, `SYS_CLK_HZ=4`, `SHIFT_CLK_HZ=1` (`CLK_DIV=2`), `i_data=8'hA5`, one-cycle start at cycle 0.
  - Data sampled at the 8 `o_serial_clk` rising edges is 1,0,1,0,0,1,0,1.
  - The first rising edge is in cycle 3.
  - Latch is high in cycles 33–34.
  - `o_done` is in cycle 35; `o_busy` is high in cycles 1–34.
- **Pending request:** same config, start at cycle 0 with `8'hFF`, `i_start` pulsed at cycles 5 and 9, `i_data` changed to `8'h3C` at cycle 20.
  - Exactly one extra transfer runs, sending 0,0,1,1,1,1,0,0.
  - Its `o_busy` rises in cycle 36.
- **Enable pause:** `i_en` low during cycles 10–19 of a transfer.
  - All outputs hold during the pause.
  - `o_done` moves to cycle 45.
  - `i_start` pulsed while `i_en` is low produces no transfer.
- **Reset mid-transfer:** `i_reset` high at cycle 12.
  - All outputs are 0 the next cycle.
  - No latch pulse and no `o_done` follow.
  - A fresh start after reset yields a correct, full frame.
- **Defaults:** `NUM_BYTES=6`, data `48'h0123456789AB`.
  - 48 clock pulses, each 2 cycles low and 2 cycles high.
  - The serial stream equals the frame, MSB first.
  - `o_done` is in cycle 195.
- **Start on done cycle:** `i_start` asserted exactly in the `o_done` cycle.
  - A new transfer starts with `o_busy` at the next cycle.
  - `pending` remains 0, so no third transfer follows.
